grid_scan: RTL

- Downstream consumer of the Game evolution stage's 64-bit registered `gridOut`.
- Time-multiplexes the 8x8 Life grid onto an 8-row x 8-column LED matrix, one row at a time.
- Latches a full frame at each frame boundary so the displayed image never tears.
- Emits `gen_tick`, a generation-pacing pulse usable as the evolution stage's clock enable.

---
 rtl/grid_scan_pkg.sv | 22 ++
 rtl/grid_scan_if.sv | 30 +++
 rtl/grid_scan_tick_prescaler.sv | 39 +++
 rtl/grid_scan.sv | 126 ++++++++++++
 4 files changed

// File: rtl/grid_scan_pkg.sv
// Shared constants, state encoding and row-extraction helper for the grid_scan LED matrix driver.
package grid_pkg;

    localparam int GRID_W    = 64;
    localparam int NUM_ROWS  = 8;
    localparam int ROW_W     = 8;
    localparam int ROW_IDX_W = $clog2(NUM_ROWS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SCAN  = 2'd2,
        BLANK = 2'd3
    } scan_state_t;

    // Cell (r,c) lives at bit 8*r+c, so a whole row is one contiguous byte.
    function automatic logic [ROW_W-1:0] row_slice(input logic [GRID_W-1:0] grid,
                                                   input logic [ROW_IDX_W-1:0] row);
        return grid[ROW_W*row +: ROW_W];
    endfunction

endpackage

// File: rtl/grid_scan_if.sv
// Display-side bundle of grid_scan: enable and grid input, row/column drive and pacing outputs.
interface grid_scan_if;
    import grid_pkg::*;

    logic              en;
    logic [GRID_W-1:0] grid_in;
    logic [ROW_W-1:0]  row_sel;
    logic [ROW_W-1:0]  col_data;
    logic              frame_start;
    logic              gen_tick;

    modport master (
        output en,
        output grid_in,
        input  row_sel,
        input  col_data,
        input  frame_start,
        input  gen_tick
    );

    modport slave (
        input  en,
        input  grid_in,
        output row_sel,
        output col_data,
        output frame_start,
        output gen_tick
    );

endinterface

// File: rtl/grid_scan_tick_prescaler.sv
// Row-dwell prescaler: counts clk cycles while run is high and pulses tc on the last cycle of a row.
module tick_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tc
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    assign tc = run && (div_cnt_q == DIV_LAST);

    // NOTE: every variable assigned in always_comb gets a default at the top, so no path can infer a latch.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clear) begin
            div_cnt_d = '0;
        end else if (run) begin
            div_cnt_d = tc ? '0 : div_cnt_q + DIV_W'(1);
        end
    end

    // NOTE: flops are written with <= only; blocking assignments here would race against readers on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/grid_scan.sv
// Tear-free row scanner for the 8x8 Life grid with generation pacing pulse.
// Define GRID_SCAN_BLANK_EN to insert one blank cycle between rows (anti-ghosting).
module grid_scan
    import grid_pkg::*;
#(
    parameter int TICK_DIV   = 1000,
    parameter int GEN_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    grid_scan_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_LOAD  = LOAD;
    localparam logic [1:0] ST_SCAN  = SCAN;
    localparam logic [1:0] ST_BLANK = BLANK;

    localparam int FC_W = (GEN_FRAMES > 1) ? $clog2(GEN_FRAMES) : 1;
    localparam logic [FC_W-1:0]      FRAME_LAST = FC_W'(GEN_FRAMES - 1);
    localparam logic [ROW_IDX_W-1:0] ROW_LAST   = ROW_IDX_W'(NUM_ROWS - 1);

    logic [1:0]           state_q,     state_d;
    logic [ROW_IDX_W-1:0] row_q,       row_d;
    logic [FC_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic [GRID_W-1:0]    frame_buf_q, frame_buf_d;
    logic                 gen_tick_q,  gen_tick_d;

    logic row_done;
    logic presc_clear;
    logic presc_run;

    assign presc_run   = (state_q == ST_SCAN);
    assign presc_clear = !bus.en || (state_q != ST_SCAN);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (presc_clear),
        .run   (presc_run),
        .tc    (row_done)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        frame_cnt_d = frame_cnt_q;
        frame_buf_d = frame_buf_q;
        gen_tick_d  = 1'b0;

        if (!bus.en) begin
            state_d     = ST_IDLE;
            row_d       = '0;
            frame_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    frame_buf_d = bus.grid_in;
                    row_d       = '0;
                    state_d     = ST_SCAN;
                end
                ST_SCAN: begin
                    if (row_done) begin
                        if (row_q != ROW_LAST) begin
                            row_d = row_q + ROW_IDX_W'(1);
`ifdef GRID_SCAN_BLANK_EN
                            state_d = ST_BLANK;
`endif
                        end else begin
                            // Frame wrap: gen_tick is registered so it coincides with the next LOAD.
                            state_d = ST_LOAD;
                            if (frame_cnt_q == FRAME_LAST) begin
                                frame_cnt_d = '0;
                                gen_tick_d  = 1'b1;
                            end else begin
                                frame_cnt_d = frame_cnt_q + FC_W'(1);
                            end
                        end
                    end
                end
                ST_BLANK: begin
                    state_d = ST_SCAN;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: frame_buf is an ordinary register bank, not a RAM, so clearing it on reset is cheap and makes the first frame deterministic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            frame_cnt_q <= '0;
            frame_buf_q <= '0;
            gen_tick_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            frame_cnt_q <= frame_cnt_d;
            frame_buf_q <= frame_buf_d;
            gen_tick_q  <= gen_tick_d;
        end
    end

    // Outputs depend only on flops; LOAD, BLANK and IDLE all blank the matrix.
    always_comb begin
        bus.row_sel  = '0;
        bus.col_data = '0;
        if (state_q == ST_SCAN) begin
            bus.row_sel  = ROW_W'(1) << row_q;
            bus.col_data = row_slice(frame_buf_q, row_q);
        end
    end

    assign bus.frame_start = (state_q == ST_LOAD);
    assign bus.gen_tick    = gen_tick_q;

endmodule
